// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
// Splits one vector load/store into LANES single-element accesses on the
// narrow data-memory port. The pipeline is held through busy while the
// elements are sequenced. Load elements are gathered into rdata_vec, and a
// single vreg_we strobe is raised when a load completes.
//
// Build option: define VMS_TIMEOUT_EN to add an ack watchdog. When no ack
// arrives for TIMEOUT_CYC consecutive request cycles, the transfer aborts
// with err. Without the macro, err is tied low and a request waits
// indefinitely for its ack.
module vector_mem_sequencer #(
  parameter int LANES       = 4,
  parameter int ELEM_W      = 8,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*ELEM_W-1:0] wdata_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    vreg_we,
  output logic                    err,
  output logic [LANES*ELEM_W-1:0] rdata_vec,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ELEM_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [ELEM_W-1:0]       mem_rdata
);

  localparam int VEC_W  = LANES * ELEM_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q,  lane_d;
  logic [ADDR_W-1:0]   base_q,  base_d;
  logic [VEC_W-1:0]    wdata_q, wdata_d;
  logic                store_q, store_d;
  logic [VEC_W-1:0]    rdata_q, rdata_d;

`ifdef VMS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q,  err_d;
`endif

  // State and datapath registers. Reset is synchronous and active-low, and
  // it wins over everything, including a transfer that is still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only. This keeps
      // every register sampling the pre-edge values of the others.
      state_q <= IDLE;
      lane_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      // NOTE: the gathered vector is a plain register rather than a memory,
      // so it is cleared on reset. A consumer never observes stale data after
      // reset.
      rdata_q <= '0;
`ifdef VMS_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
`ifdef VMS_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic and output decode. Every output is decoded from the
  // registers above. mem_ack only steers the next state, so nothing on the
  // memory port depends combinationally on the ack.
  always_comb begin
    // NOTE: all signals written here get a default first, so no branch leaves
    // one unassigned and no latch is inferred.
    state_d   = state_q;
    lane_d    = lane_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    store_d   = store_q;
    rdata_d   = rdata_q;
`ifdef VMS_TIMEOUT_EN
    wait_d    = wait_q;
    err_d     = 1'b0;
`endif
    busy      = 1'b0;
    done      = 1'b0;
    vreg_we   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        // Operands are captured only here. Upstream may change them freely
        // while the transfer runs.
        if (start) begin
          base_d  = base_addr;
          wdata_d = wdata_vec;
          store_d = is_store;
          lane_d  = '0;
`ifdef VMS_TIMEOUT_EN
          wait_d  = '0;
`endif
          state_d = REQ;
        end
      end

      REQ: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = store_q;
        // The address wraps modulo 2^ADDR_W by plain truncation.
        mem_addr  = base_q + ADDR_W'(lane_q);
        mem_wdata = wdata_q[int'(lane_q)*ELEM_W +: ELEM_W];

        if (mem_ack) begin
          if (!store_q) begin
            rdata_d[int'(lane_q)*ELEM_W +: ELEM_W] = mem_rdata;
          end
          if (lane_q == LAST_LANE) begin
            state_d = DONE;
          end else begin
            // Stay in REQ, so the next element is requested back-to-back.
            lane_d = lane_q + LANE_W'(1);
          end
`ifdef VMS_TIMEOUT_EN
          wait_d = '0;
`endif
        end
`ifdef VMS_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          // This is the TIMEOUT_CYC-th request cycle without an ack, so the
          // transfer aborts. Lanes already gathered stay in rdata_vec.
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end

      DONE: begin
        done = 1'b1;
`ifdef VMS_TIMEOUT_EN
        // An aborted load must not commit its partial vector.
        vreg_we = ~store_q & ~err_q;
`else
        vreg_we = ~store_q;
`endif
        lane_d  = '0;
        // start is ignored here. If upstream still holds it in the next
        // IDLE cycle, that counts as a new request.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered view of the gathered vector. It holds its value between
  // operations, and stores leave it untouched.
  assign rdata_vec = rdata_q;

`ifdef VMS_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer
// Randomised scoreboard bench for vector_mem_sequencer. The stimulus side
// derives, from a transaction-level reference, the list of element accesses
// and the completion record each operation should produce, and queues them.
// A monitor pops and compares them whenever the DUT shows an acked access or
// a done pulse. A behavioural memory answers requests with a programmable
// ack delay.
module tb_vector_mem_sequencer;

  localparam int LANES       = 4;
  localparam int ELEM_W      = 8;
  localparam int ADDR_W      = 32;
  localparam int TIMEOUT_CYC = 16;
  localparam int VW          = LANES * ELEM_W;

  logic              clk       = 1'b0;
  logic              rst       = 1'b0;
  logic              start     = 1'b0;
  logic              is_store  = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [VW-1:0]     wdata_vec = '0;
  logic              busy, done, vreg_we, err;
  logic [VW-1:0]     rdata_vec;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic              mem_ack   = 1'b0;
  logic [ELEM_W-1:0] mem_rdata = '0;

  vector_mem_sequencer #(
    .LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .base_addr(base_addr), .wdata_vec(wdata_vec), .busy(busy), .done(done),
    .vreg_we(vreg_we), .err(err), .rdata_vec(rdata_vec), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [ELEM_W-1:0] wdata;
    int                cyc;    // -1: timing not checked
  } acc_t;

  typedef struct {
    logic          vreg_we;
    logic          err;
    logic [VW-1:0] rdata;
    int            cyc;        // -1: timing not checked
  } done_t;

  acc_t  exp_acc[$];
  done_t exp_done[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference memory (what memory should hold) and the physical memory
  // actually written by the DUT. Unwritten locations read a fixed hash.
  logic [ELEM_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
  logic [ELEM_W-1:0] phys_mem [logic [ADDR_W-1:0]];
  logic [VW-1:0]     model_rdata = '0;

  function automatic logic [ELEM_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [ELEM_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [ELEM_W-1:0] phys_rd(input logic [ADDR_W-1:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
  endfunction

  // Memory responder: acks the current request after cur_delay wait cycles.
  // It can refuse one address (hold_en), or pulse a stray ack (stray).
  int                cur_delay = 0;
  int                resp_wait = 0;
  bit                hold_en   = 1'b0;
  bit                stray     = 1'b0;
  logic [ADDR_W-1:0] hold_addr = '0;

  initial forever begin
    @(posedge clk);
    #1;
    if (stray) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'hEE;
    end else if (mem_req === 1'b1 && !(hold_en && mem_addr == hold_addr)) begin
      if (resp_wait >= cur_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = phys_rd(mem_addr);
        if (mem_we) phys_mem[mem_addr] = mem_wdata;
        resp_wait = 0;
      end else begin
        mem_ack   = 1'b0;
        resp_wait++;
      end
    end else begin
      mem_ack   = 1'b0;
      resp_wait = 0;
    end
  end

  // Monitor: compares acked accesses, request stability and done records.
  bit                hv = 1'b0;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [ELEM_W-1:0] h_wdata;
  acc_t              ma;
  done_t             md;

  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (hv) begin
        check("req_addr_stable", mem_addr, h_addr);
        check("req_we_stable", mem_we, h_we);
        check("req_wdata_stable", mem_wdata, h_wdata);
      end
      if (mem_ack === 1'b1) begin
        hv = 1'b0;
        check("busy_during_req", busy, 1);
        if (exp_acc.size() == 0) begin
          check("unexpected_access", exp_acc.size(), 1);
        end else begin
          ma = exp_acc.pop_front();
          check("acc_we", mem_we, ma.we);
          check("acc_addr", mem_addr, ma.addr);
          if (ma.we) check("acc_wdata", mem_wdata, ma.wdata);
          if (ma.cyc >= 0) check("acc_cycle", cyc, ma.cyc);
        end
      end else begin
        hv      = 1'b1;
        h_we    = mem_we;
        h_addr  = mem_addr;
        h_wdata = mem_wdata;
      end
    end else begin
      hv = 1'b0;
    end

    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", exp_done.size(), 1);
      end else begin
        md = exp_done.pop_front();
        check("done_vreg_we", vreg_we, md.vreg_we);
        check("done_err", err, md.err);
        check("done_rdata", rdata_vec, md.rdata);
        if (md.cyc >= 0) check("done_cycle", cyc, md.cyc);
      end
    end else begin
      if (vreg_we === 1'b1) check("vreg_we_without_done", vreg_we, 0);
      if (err === 1'b1) check("err_without_done", err, 0);
    end
  end

  // Reference model for one operation issued at cycle s. Element i goes to
  // base+i (32-bit wrap). When timed (ack every cycle), element i is acked at
  // s+1+i. Done follows LANES+2 cycles counting the start and done cycles.
  task automatic push_op(input logic st, input logic [ADDR_W-1:0] base,
                         input logic [VW-1:0] wd, input bit timed, input int s);
    acc_t  a;
    done_t d;
    for (int i = 0; i < LANES; i++) begin
      a.we    = st;
      a.addr  = base + ADDR_W'(i);
      a.wdata = wd[i*ELEM_W +: ELEM_W];
      a.cyc   = timed ? s + 1 + i : -1;
      if (st) ref_mem[a.addr] = a.wdata;
      else model_rdata[i*ELEM_W +: ELEM_W] = ref_rd(a.addr);
      exp_acc.push_back(a);
    end
    d.vreg_we = ~st;
    d.err     = 1'b0;
    d.rdata   = model_rdata;
    d.cyc     = timed ? s + LANES + 1 : -1;
    exp_done.push_back(d);
  endtask

  task automatic issue(input logic st, input logic [ADDR_W-1:0] base,
                       input logic [VW-1:0] wd, input int dly);
    @(posedge clk); #2;
    cur_delay = dly;
    is_store  = st;
    base_addr = base;
    wdata_vec = wd;
    start     = 1'b1;
    push_op(st, base, wd, dly == 0, cyc);
    @(posedge clk); #2;
    // Scramble the operands, which must have been latched on start.
    start     = 1'b0;
    is_store  = 1'($urandom_range(0, 1));
    base_addr = $urandom;
    wdata_vec = VW'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("op_done_seen", done, 1);
  endtask

  task automatic flush_after_reset();
    exp_acc.delete();
    exp_done.delete();
    model_rdata = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got t=%0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin : main
    logic [ADDR_W-1:0] base;
    logic [VW-1:0]     wd;
    logic              st;
    int                s;
    bit                found;
    acc_t              a;
    done_t             d;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vreg_we", vreg_we, 0);
    check("rst_err", err, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rdata", rdata_vec, 0);
    @(posedge clk); #2;
    rst = 1'b1;

    // Load from 0x100 with an ack every cycle.
    for (int i = 0; i < LANES; i++) begin
      ref_mem[32'h100 + ADDR_W'(i)]  = ELEM_W'(8'h11 * (i + 1));
      phys_mem[32'h100 + ADDR_W'(i)] = ELEM_W'(8'h11 * (i + 1));
    end
    issue(1'b0, 32'h100, VW'($urandom), 0);
    wait_done(32);
    check("load_rdata_vec", rdata_vec, 32'h4433_2211);

    // Store with every ack delayed 2 cycles.
    issue(1'b1, 32'h20, 32'hDDCC_BBAA, 2);
    wait_done(64);
    check("store_keeps_rdata", rdata_vec, 32'h4433_2211);
    check("store_mem_image", {phys_rd(32'h23), phys_rd(32'h22), phys_rd(32'h21), phys_rd(32'h20)},
          32'hDDCC_BBAA);

    // Load whose addresses wrap past the top of the address space.
    issue(1'b0, 32'hFFFF_FFFE, VW'($urandom), 0);
    wait_done(32);

    // Read back the stored vector.
    issue(1'b0, 32'h20, VW'($urandom), 1);
    wait_done(64);
    check("readback_store", rdata_vec, 32'hDDCC_BBAA);

    // Stray ack in IDLE must be ignored.
    @(posedge clk); #2;
    stray = 1'b1;
    @(posedge clk); #2;
    stray = 1'b0;
    check("stray_ack_driven", mem_ack, 1);
    check("stray_busy", busy, 0);
    @(posedge clk); #2;
    check("stray_after_busy", busy, 0);
    check("stray_after_req", mem_req, 0);
    check("stray_after_done", done, 0);
    check("stray_after_rdata", rdata_vec, model_rdata);

    // Start held across done: a second transfer starts right after DONE.
    @(posedge clk); #2;
    cur_delay = 0;
    is_store  = 1'b0;
    base_addr = 32'h100;
    wd        = VW'($urandom);
    wdata_vec = wd;
    start     = 1'b1;
    s         = cyc;
    push_op(1'b0, 32'h100, wd, 1'b1, s);
    push_op(1'b0, 32'h100, wd, 1'b1, s + LANES + 2);
    repeat (LANES + 3) begin
      @(posedge clk); #2;
    end
    start = 1'b0;
    wait_done(32);

    // Randomised mix of loads and stores with random ack delays.
    for (int k = 0; k < 40; k++) begin
      st = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       base = 32'hFFFF_FFFC + ADDR_W'($urandom_range(0, 3));
        1:       base = $urandom;
        default: base = 32'h100 + ADDR_W'($urandom_range(0, 15));
      endcase
      wd = VW'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(st, base, wd, int'($urandom_range(0, 3)));
      wait_done(64);
    end

    // Reset right after the lane-2 ack: abandon the transfer, no done.
    issue(1'b0, 32'h300, VW'($urandom), 0);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (mem_req && mem_ack && mem_addr == 32'h302) begin
        rst   = 1'b0;
        found = 1'b1;
      end else begin
        @(posedge clk); #2;
      end
    end
    check("lane2_ack_seen", found, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    flush_after_reset();
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_done", done, 0);
    check("midrst_rdata", rdata_vec, 0);
    repeat (6) @(negedge clk);
    check("midrst_still_idle", busy, 0);

    // Lane 1 never acked: the watchdog aborts, or busy stalls forever.
    hold_en   = 1'b1;
    hold_addr = 32'h501;
    @(posedge clk); #2;
    cur_delay = 0;
    is_store  = 1'b0;
    base_addr = 32'h500;
    start     = 1'b1;
    s         = cyc;
    a.we      = 1'b0;
    a.addr    = 32'h500;
    a.wdata   = '0;
    a.cyc     = s + 1;
    exp_acc.push_back(a);
    model_rdata[ELEM_W-1:0] = ref_rd(32'h500);
    @(posedge clk); #2;
    start = 1'b0;
`ifdef VMS_TIMEOUT_EN
    d.vreg_we = 1'b0;
    d.err     = 1'b1;
    d.rdata   = model_rdata;
    d.cyc     = s + 2 + TIMEOUT_CYC;
    exp_done.push_back(d);
    wait_done(64);
`else
    repeat (40) @(negedge clk);
    check("stall_busy", busy, 1);
    check("stall_addr", mem_addr, 32'h501);
    check("stall_no_done", done, 0);
    check("stall_err", err, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    flush_after_reset();
    @(negedge clk);
    check("stall_recovered", busy, 0);
`endif
    hold_en = 1'b0;

    // Normal operation resumes.
    issue(1'b0, 32'h100, VW'($urandom), 0);
    wait_done(32);

    repeat (4) @(negedge clk);
    check("acc_queue_empty", exp_acc.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
